// File: rtl/muldiv_sequencer_if.sv
// Handshake and data bundle between the EX stage and the iterative mul/div unit.
// The master drives the request side; the slave (the unit) returns stall, done and result.
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             StartE;
  logic [1:0]       OpE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic [WIDTH-1:0] SrcCE;
  logic             FlushE;
  logic             StallMD;
  logic             DoneE;
  logic [WIDTH-1:0] ResultE;
  logic             BusyE;

  modport master (
    output StartE, OpE, SrcAE, SrcBE, SrcCE, FlushE,
    input  StallMD, DoneE, ResultE, BusyE
  );

  modport slave (
    input  StartE, OpE, SrcAE, SrcBE, SrcCE, FlushE,
    output StallMD, DoneE, ResultE, BusyE
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative EX-stage multiply/divide unit: radix-2 shift-add multiply (with optional
// accumulate) and unsigned restoring divide, one iteration per cycle, stalling the front end.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [1:0] OpMul  = 2'b00;
  localparam logic [1:0] OpMla  = 2'b01;
  localparam logic [1:0] OpUdiv = 2'b10;
  localparam logic [1:0] OpUrem = 2'b11;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   addend_q, addend_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               accept;
  logic               div_zero;
  logic               last_iter;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH+1:0]   rem_shift;
  logic [WIDTH+1:0]   rem_diff;
  logic [WIDTH:0]     rem_step;
  logic [WIDTH-1:0]   quo_step;

  assign accept    = bus.StartE & ~bus.FlushE & (state_q != StRun);
  assign div_zero  = bus.OpE[1] & (bus.SrcBE == '0);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // One multiply step and one restoring-divide step; the borrow of the trial
  // subtraction decides whether the shifted remainder is restored.
  always_comb begin
    prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_diff  = rem_shift - {2'b00, dvsr_q};
    if (rem_diff[WIDTH+1]) begin
      rem_step = rem_shift[WIDTH:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_step = rem_diff[WIDTH:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    addend_d = addend_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    result_d = result_q;

    case (state_q)
      StRun: begin
        if (bus.FlushE) begin
          state_d = StIdle;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          prod_d   = prod_step;
          mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
          rem_d    = rem_step;
          quo_d    = quo_step;
          if (last_iter) begin
            state_d = StDone;
            case (op_q)
              OpMul:   result_d = prod_step[WIDTH-1:0];
              OpMla:   result_d = prod_step[WIDTH-1:0] + addend_q;
              OpUdiv:  result_d = quo_step;
              OpUrem:  result_d = rem_step[WIDTH-1:0];
              default: result_d = result_q;
            endcase
          end
        end
      end
      default: begin
        state_d = StIdle;
        if (accept) begin
          op_d     = bus.OpE;
          cnt_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, bus.SrcAE};
          prod_d   = '0;
          mplier_d = bus.SrcBE;
          addend_d = bus.SrcCE;
          rem_d    = '0;
          quo_d    = bus.SrcAE;
          dvsr_d   = bus.SrcBE;
          if (div_zero) begin
            state_d  = StDone;
            result_d = bus.OpE[0] ? bus.SrcAE : '1;
          end else begin
            state_d = StRun;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= OpMul;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      addend_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      addend_q <= addend_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
    end
  end

  // Combinational so the requesting instruction is held in EX from its first cycle.
  assign bus.StallMD = accept | (state_q == StRun);
  assign bus.DoneE   = (state_q == StDone);
  assign bus.BusyE   = (state_q == StRun);
  assign bus.ResultE = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases with literal results plus
// randomized traffic compared every cycle against a transaction-level reference model.
module tb_muldiv_sequencer;
  localparam int unsigned W = 32;

  logic clk;
  logic reset;
  int   checks;
  int   passes;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] op,
                                          input logic [W-1:0] a, b, c);
    logic [W-1:0] r;
    case (op)
      2'd0:    r = a * b;
      2'd1:    r = a * b + c;
      2'd2:    r = (b == '0) ? '1 : a / b;
      default: r = (b == '0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Reference model: cycles left in an op, a done flag, and the held result.
  int           m_left;
  logic         m_done;
  logic [W-1:0] m_res;
  logic [W-1:0] m_pend;
  logic         exp_stall;

  always @(negedge clk) begin
    if (reset) begin
      m_left = 0;
      m_done = 1'b0;
      m_res  = '0;
      chk("rst_done", W'(bus.DoneE), '0);
      chk("rst_busy", W'(bus.BusyE), '0);
      chk("rst_result", bus.ResultE, '0);
      chk("rst_stall", W'(bus.StallMD), W'(bus.StartE & ~bus.FlushE));
    end else begin
      exp_stall = (m_left > 0) || (bus.StartE && !bus.FlushE);
      chk("stall", W'(bus.StallMD), W'(exp_stall));
      chk("done", W'(bus.DoneE), W'(m_done));
      chk("busy", W'(bus.BusyE), W'(m_left > 0));
      chk("result", bus.ResultE, m_res);
      m_done = 1'b0;
      if (m_left > 0) begin
        if (bus.FlushE) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_done = 1'b1;
            m_res  = m_pend;
          end
        end
      end else if (bus.StartE && !bus.FlushE) begin
        m_pend = ref_op(bus.OpE, bus.SrcAE, bus.SrcBE, bus.SrcCE);
        if (bus.OpE[1] && bus.SrcBE == '0) begin
          m_done = 1'b1;
          m_res  = m_pend;
        end else begin
          m_left = W;
        end
      end
    end
  end

  task automatic idle(input int n);
    bus.StartE = 1'b0;
    bus.FlushE = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds StartE like a stalled EX instruction; returns in the DoneE cycle with StartE still high.
  task automatic do_op(input string name, input logic [1:0] op, input logic [W-1:0] a, b, c,
                       input logic [W-1:0] exp_res, input int exp_lat);
    int n;
    int stalls;
    n = 0;
    stalls = 0;
    bus.StartE = 1'b1;
    bus.FlushE = 1'b0;
    bus.OpE    = op;
    bus.SrcAE  = a;
    bus.SrcBE  = b;
    bus.SrcCE  = c;
    while (n < 100) begin
      @(negedge clk);
      if (bus.StallMD) stalls++;
      @(posedge clk);
      #1;
      n++;
      if (bus.DoneE) break;
    end
    chk({name, "_result"}, bus.ResultE, exp_res);
    chk({name, "_latency"}, W'(n), W'(exp_lat));
    chk({name, "_stall_cycles"}, W'(stalls), W'(exp_lat));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    passes = 0;
    reset = 1'b1;
    bus.StartE = 1'b0;
    bus.FlushE = 1'b0;
    bus.OpE    = 2'd0;
    bus.SrcAE  = '0;
    bus.SrcBE  = '0;
    bus.SrcCE  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    do_op("mul_7x6", 2'd0, 7, 6, 0, 42, W + 1);
    idle(1);
    chk("mul_back_to_idle", W'(bus.BusyE | bus.DoneE), '0);
    do_op("mla_5x3p15", 2'd1, 5, 3, 15, 30, W + 1);
    idle(1);
    do_op("mul_trunc", 2'd0, 32'hFFFF_FFFF, 2, 0, 32'hFFFF_FFFE, W + 1);
    idle(1);
    do_op("udiv_100_7", 2'd2, 100, 7, 0, 14, W + 1);
    idle(1);
    do_op("urem_100_7", 2'd3, 100, 7, 0, 2, W + 1);
    idle(1);
    do_op("udiv_9_1", 2'd2, 9, 1, 0, 9, W + 1);
    idle(1);
    do_op("udiv_8_0", 2'd2, 8, 0, 0, 32'hFFFF_FFFF, 1);
    idle(1);
    do_op("urem_8_0", 2'd3, 8, 0, 0, 8, 1);
    idle(2);

    // Flush in the tenth RUN cycle: no DoneE, result holds 8, stall drops next cycle.
    bus.StartE = 1'b1;
    bus.OpE    = 2'd0;
    bus.SrcAE  = 9;
    bus.SrcBE  = 9;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    bus.StartE = 1'b0;
    bus.FlushE = 1'b1;
    @(posedge clk);
    #1;
    bus.FlushE = 1'b0;
    @(negedge clk);
    chk("flush_stall_drop", W'(bus.StallMD), '0);
    chk("flush_result_held", bus.ResultE, 8);
    idle(40);
    chk("flush_no_done_result", bus.ResultE, 8);
    do_op("mul_3x5", 2'd0, 3, 5, 0, 15, W + 1);
    idle(1);

    // Back-to-back: the second request arrives during the DONE cycle of the first.
    do_op("b2b_mul_2x4", 2'd0, 2, 4, 0, 8, W + 1);
    do_op("b2b_udiv_30_2", 2'd2, 30, 2, 0, 15, W + 1);
    idle(2);

    // Asynchronous reset in the middle of RUN.
    bus.StartE = 1'b1;
    bus.OpE    = 2'd1;
    bus.SrcAE  = 11;
    bus.SrcBE  = 13;
    bus.SrcCE  = 1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    bus.StartE = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_rst_result", bus.ResultE, '0);
    chk("async_rst_busy", W'(bus.BusyE), '0);
    chk("async_rst_done", W'(bus.DoneE), '0);
    chk("async_rst_stall", W'(bus.StallMD), '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // Random traffic, including operand churn during RUN and flushes at any time.
    for (int i = 0; i < 3000; i++) begin
      bus.StartE = ($urandom_range(0, 2) != 0);
      bus.OpE    = 2'($urandom_range(0, 3));
      bus.SrcAE  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : $urandom;
      case ($urandom_range(0, 7))
        0:       bus.SrcBE = '0;
        1, 2:    bus.SrcBE = W'($urandom_range(1, 15));
        default: bus.SrcBE = $urandom;
      endcase
      bus.SrcCE  = $urandom;
      bus.FlushE = ($urandom_range(0, 63) == 0);
      @(posedge clk);
      #1;
    end
    idle(W + 4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multi-cycle multiply/divide unit for the Execute stage of the pipelined ARM core.
- It accepts an operation from decoded EX-stage operands: SrcAE, SrcBE, and the third register operand rd3E as the accumulator.
- It runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles.
- While the operation runs, it stalls the front of the pipeline, then presents the result for one cycle so the instruction can advance to Memory.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- StartE  input  1  EX instruction is a mul/div op requesting service.
- OpE  input  2  00 MUL (a*b low), 01 MLA (a*b+c low), 10 UDIV (a/b), 11 UREM (a%b).
- SrcAE  input  WIDTH  operand a (multiplicand/dividend).
- SrcBE  input  WIDTH  operand b (multiplier/divisor).
- SrcCE  input  WIDTH  accumulator c; used by MLA only.
- FlushE  input  1  EX flush (branch taken); cancels a request or an in-flight op.
- StallMD  output  1  stall request to the hazard unit; freezes F/D/E.
- DoneE  output  1  single-cycle pulse: ResultE is valid this cycle.
- ResultE  output  WIDTH  operation result; held until the next accepted start.
- BusyE  output  1  high in RUN state.

Behaviour:
- Reset values (async): state=IDLE, counter=0, ResultE=0, DoneE=0, BusyE=0. StallMD=0 unless StartE is high.
- States are IDLE, RUN, DONE.
- Accept condition: StartE & ~FlushE while in IDLE or DONE. On accept, latch OpE/SrcAE/SrcBE/SrcCE and set counter=0.
  - If OpE is UDIV/UREM and SrcBE==0, the next state is DONE (divide-by-zero fast path).
  - Otherwise the next state is RUN.
- RUN performs one iteration per cycle. The counter increments; when counter==WIDTH-1 the next state is DONE.
- Latency: accept on edge k, so DoneE is high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after the request cycle. For the div-by-zero path it is 1 cycle.
- DONE: DoneE=1 and ResultE is valid. Next state:
  - RUN or DONE if a new accept occurs (back-to-back, no idle bubble);
  - otherwise IDLE.
- StallMD = (StartE & ~FlushE & state in {IDLE, DONE}) | (state==RUN). It is combinational so the requesting instruction holds in EX from its first cycle. StallMD is low in DONE unless a new request is present.
- Multiply:
  - Internal 2*WIDTH product; each iteration adds the shifted multiplicand if the multiplier LSB is set.
  - MUL result = low WIDTH bits.
  - MLA result = (low WIDTH bits + SrcCE) mod 2^WIDTH; the add happens on the RUN->DONE transition.
- Divide: unsigned restoring, one quotient bit per iteration, with a WIDTH+1-bit partial remainder. UDIV returns the quotient; UREM returns the remainder.
- Divide by zero: UDIV returns all-ones; UREM returns SrcAE (the latched dividend).
- ResultE updates only when entering DONE. DoneE is never asserted for a cancelled op.
- Flush:
  - FlushE in RUN causes next state IDLE. DoneE stays 0, ResultE is unchanged, and StallMD drops the following cycle.
  - FlushE together with StartE in IDLE/DONE means no accept.
- Operand changes on the SrcXE inputs during RUN are ignored; only the latched copies are used.
- StartE high while in RUN is ignored; it is the same stalled instruction.
- Reset mid-operation: state returns to IDLE immediately. The result is discarded and ResultE=0.

Test Plan:
- MUL 7*6, StartE held per stall: StallMD high for 33 cycles; DoneE pulse with ResultE=42, then IDLE.
- MLA a=5, b=3, c=15 -> ResultE=30. Also MUL 0xFFFFFFFF*2 -> ResultE=0xFFFFFFFE (low-word truncation).
- UDIV 100/7 -> 14; UREM 100%7 -> 2; UDIV 9/1 -> 9; each with latency WIDTH+1.
- UDIV 8/0 -> DoneE one cycle after accept, ResultE=0xFFFFFFFF. UREM 8/0 -> ResultE=8.
- FlushE asserted at RUN cycle 10 -> no DoneE, ResultE keeps its prior value, StallMD=0 next cycle. A subsequent MUL 3*5 -> 15.
- Back-to-back: MUL 2*4 then StartE present during DONE with UDIV 30/2. Second op is accepted with no IDLE cycle; results are 8 then 15. Reset asserted mid-RUN -> all outputs 0 asynchronously.
